// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// No logic; forwarding selects and the multicycle FSM state type.
// Imported by fwd_sel and hazard_ctrl.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand bypass select for one execute-stage source register.
// Latency: combinational.
// Backpressure: none; the caller gates the result during reset.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    // x0 is hardwired to zero, so a write to it must never be bypassed.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: bypass selects, load-use/branch/multicycle stalls and flushes.
// Latency: stall/flush/fwd combinational; mc_err and counters registered.
// Backpressure: mem_busy freezes every stage and holds the FSM and watchdog.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_MAX = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              mem_read_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mc_start_e,
    input  logic              mc_done,
    input  logic              mem_busy,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mc_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                WD_W    = (MC_MAX > 2) ? $clog2(MC_MAX) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(MC_MAX - 1);
    localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    hz_state_t        state;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_inc;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;
    logic             load_use;
    logic             mc_hold;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_a_raw)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_b_raw)
    );

    assign fwd_a_e  = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b_e  = rst ? FWD_RF : fwd_b_raw;
    assign wd_inc   = wd + WD_ONE;
    assign load_use = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // The issue cycle already holds execute unless the result is ready at once.
    assign mc_hold  = (state == RUN) ? (mc_start_e && !mc_done) : !mc_done;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (mc_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wd        <= '0;
            mc_err    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mc_err <= 1'b0;
            if (!mem_busy) begin
                case (state)
                    RUN: begin
                        if (mc_start_e && !mc_done) begin
                            state <= MC_WAIT;
                            wd    <= '0;
                        end
                    end
                    MC_WAIT: begin
                        if (mc_done) begin
                            state <= RUN;
                        end else if (wd_inc == WD_LAST) begin
                            state  <= RUN;
                            mc_err <= 1'b1;
                        end else begin
                            wd <= wd_inc;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
            if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    logic unused_ok;
    assign unused_ok = reg_write_e;

endmodule
